dbp_buf_sched: RTL and testbench

Ping-pong scheduler that shares one decoded word stream between two `buffer` instances in the EBPC decoder. It steers each block (one base word, then DATA_W+1 delta bit-planes) into alternating buffers, generates their push, valid and clear controls, and merges their `dbp_block_t` outputs back into one in-order block stream. While one buffer waits on a stalled downstream, the other keeps filling, which hides the buffer's handoff bubble.

---
 rtl/dbp_buf_sched.sv | 117 +++++++++++
 tb/tb_dbp_buf_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbp_buf_sched.sv
// Ping-pong block scheduler for the EBPC decoder.
// Steers each incoming block (base word + NUM_DBP bit-planes) into one of
// two buffers in alternation, and merges the two buffer outputs back into a
// single in-order block stream.

package ebpc_pkg;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned BLOCK_SIZE = 8;
  localparam int unsigned NUM_DBP    = DATA_W + 1;

  // One decoded block: base word plus one (BLOCK_SIZE-1)-bit delta plane per bit.
  typedef struct packed {
    logic [DATA_W-1:0]                      base;
    logic [NUM_DBP-1:0][BLOCK_SIZE-2:0]     dbp;
  } dbp_block_t;
endpackage

module dbp_buf_sched #(
  parameter int unsigned DATA_W     = ebpc_pkg::DATA_W,
  parameter int unsigned BLOCK_SIZE = ebpc_pkg::BLOCK_SIZE
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [DATA_W-1:0]               data_i,
  input  logic                            vld_i,
  output logic                            rdy_o,
  input  logic                            flush_i,
  output logic [DATA_W-1:0]               buf_data_o,
  output logic [1:0]                      buf_push_o,
  output logic [1:0]                      buf_vld_o,
  input  logic [1:0]                      buf_rdy_i,
  output logic                            buf_clr_o,
  input  ebpc_pkg::dbp_block_t [1:0]      blk_i,
  input  logic [1:0]                      blk_vld_i,
  output logic [1:0]                      blk_rdy_o,
  output ebpc_pkg::dbp_block_t            blk_o,
  output logic                            blk_vld_o,
  input  logic                            blk_rdy_i,
  output logic                            idle_o
);

  localparam int unsigned NUM_DBP = DATA_W + 1;
  localparam int unsigned CNT_W   = $clog2(NUM_DBP + 1);
  // Flat width of one block; must agree with the package block type.
  localparam int unsigned BLK_W   = DATA_W + NUM_DBP * (BLOCK_SIZE - 1);

  logic             wr_sel_reg;
  logic             rd_sel_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       inflight_reg;

  logic             accept;
  logic             last_word;
  logic             blk_done;
  logic             drain;
  logic [BLK_W-1:0] blk_sel;

  // Write side: the upstream only sees the buffer currently being filled.
  assign rdy_o      = ~flush_i & buf_rdy_i[wr_sel_reg];
  assign accept     = vld_i & rdy_o;
  assign last_word  = (cnt_reg == CNT_W'(NUM_DBP));
  assign blk_done   = accept & last_word;
  assign buf_data_o = data_i;
  assign buf_clr_o  = flush_i;

  // Read side: only the buffer holding the oldest block is observed.
  assign blk_sel   = blk_i[rd_sel_reg];
  assign blk_o     = ebpc_pkg::dbp_block_t'(blk_sel);
  assign blk_vld_o = ~flush_i & blk_vld_i[rd_sel_reg];
  assign drain     = blk_vld_o & blk_rdy_i;

  assign idle_o = (cnt_reg == '0) && (inflight_reg == 3'd0);

  // Per-buffer push/complete/ready strobes; the unselected buffer sees zeros.
  always_comb begin
    buf_push_o             = 2'b00;
    buf_vld_o              = 2'b00;
    blk_rdy_o              = 2'b00;
    buf_push_o[wr_sel_reg] = accept;
    buf_vld_o[wr_sel_reg]  = blk_done;
    blk_rdy_o[rd_sel_reg]  = blk_rdy_i;
  end

  // Scheduler state: word count, fill/drain selects and completed-block count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_sel_reg   <= 1'b0;
      rd_sel_reg   <= 1'b0;
      cnt_reg      <= '0;
      inflight_reg <= 3'd0;
    end else if (flush_i) begin
      // Flush wins over any accept or drain in the same cycle.
      wr_sel_reg   <= 1'b0;
      rd_sel_reg   <= 1'b0;
      cnt_reg      <= '0;
      inflight_reg <= 3'd0;
    end else begin
      if (accept) begin
        if (last_word) begin
          cnt_reg    <= '0;
          wr_sel_reg <= ~wr_sel_reg;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
      if (drain) begin
        rd_sel_reg <= ~rd_sel_reg;
      end
      case ({blk_done, drain})
        2'b10:   inflight_reg <= inflight_reg + 3'd1;
        2'b01:   inflight_reg <= inflight_reg - 3'd1;
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_dbp_buf_sched.sv
// Self-checking bench for dbp_buf_sched: two behavioural buffers drive the
// DUT, and a block-level scoreboard predicts every output cycle by cycle.

module tb_dbp_buf_sched;

  localparam int DW = ebpc_pkg::DATA_W;
  localparam int BS = ebpc_pkg::BLOCK_SIZE;
  localparam int ND = DW + 1;

  logic                        clk_i = 1'b0;
  logic                        rst_ni = 1'b0;
  logic [DW-1:0]               data_i;
  logic                        vld_i;
  logic                        rdy_o;
  logic                        flush_i;
  logic [DW-1:0]               buf_data_o;
  logic [1:0]                  buf_push_o;
  logic [1:0]                  buf_vld_o;
  logic [1:0]                  buf_rdy_i;
  logic                        buf_clr_o;
  ebpc_pkg::dbp_block_t [1:0]  blk_i;
  logic [1:0]                  blk_vld_i;
  logic [1:0]                  blk_rdy_o;
  ebpc_pkg::dbp_block_t        blk_o;
  logic                        blk_vld_o;
  logic                        blk_rdy_i;
  logic                        idle_o;

  always #5 clk_i = ~clk_i;

  dbp_buf_sched dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .data_i     (data_i),
    .vld_i      (vld_i),
    .rdy_o      (rdy_o),
    .flush_i    (flush_i),
    .buf_data_o (buf_data_o),
    .buf_push_o (buf_push_o),
    .buf_vld_o  (buf_vld_o),
    .buf_rdy_i  (buf_rdy_i),
    .buf_clr_o  (buf_clr_o),
    .blk_i      (blk_i),
    .blk_vld_i  (blk_vld_i),
    .blk_rdy_o  (blk_rdy_o),
    .blk_o      (blk_o),
    .blk_vld_o  (blk_vld_o),
    .blk_rdy_i  (blk_rdy_i),
    .idle_o     (idle_o)
  );

  // A completed block and the first cycle it may appear on an output.
  typedef struct {
    ebpc_pkg::dbp_block_t blk;
    int                   rc;
  } ent_t;

  // Behavioural buffers (driven by the DUT's strobes).
  ent_t          bq0[$];
  ent_t          bq1[$];
  logic [DW-1:0] part [2][0:ND];
  int            pcnt [2];

  // Scoreboard: expected completed blocks in completion order.
  ent_t          exp_q[$];
  logic [DW-1:0] mw [0:ND];
  int            mcnt, mwr, mrd, cyc;

  logic [DW-1:0] src_q[$];
  int checks = 0;
  int errors = 0;
  int vld_pct = 100, blk_rdy_pct = 100, stall_pct = 0, flush_pmil = 0;
  bit force_flush = 0;
  int out_cnt = 0, bubble_cnt = 0;

  function automatic ebpc_pkg::dbp_block_t mk_blk(input logic [DW-1:0] w [0:ND]);
    ebpc_pkg::dbp_block_t b;
    b.base = w[0];
    for (int i = 0; i < ND; i++) b.dbp[i] = w[i+1][DW-1 -: BS-1];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mcnt = 0; mwr = 0; mrd = 0;
    exp_q.delete();
  endtask

  task automatic bufs_reset();
    bq0.delete(); bq1.delete();
    pcnt[0] = 0; pcnt[1] = 0;
  endtask

  task automatic push_block(input logic [DW-1:0] base, input logic [DW-1:0] plane, input bit rnd);
    src_q.push_back(base);
    for (int i = 0; i < ND; i++) src_q.push_back(rnd ? DW'($urandom) : plane);
  endtask

  task automatic drive_buf();
    buf_rdy_i[0] = (bq0.size() < 2) && !($urandom_range(99) < stall_pct);
    buf_rdy_i[1] = (bq1.size() < 2) && !($urandom_range(99) < stall_pct);
    blk_vld_i[0] = (bq0.size() > 0) && (bq0[0].rc <= cyc);
    blk_vld_i[1] = (bq1.size() > 0) && (bq1[0].rc <= cyc);
    blk_i[0]     = (bq0.size() > 0) ? bq0[0].blk : '0;
    blk_i[1]     = (bq1.size() > 0) ? bq1[0].blk : '0;
  endtask

  // One clock cycle: drive, check against the scoreboard, advance both models.
  task automatic step();
    logic e_rdy, e_acc, e_bv;
    logic [1:0] e_push, e_bvo, e_brdy;
    logic [1:0] s_push, s_bvld, s_brdy, s_bvi;
    logic s_clr, s_flush, s_brin;
    logic [DW-1:0] s_data;
    logic [DW-1:0] tmp [0:ND];
    ent_t e;
    if (src_q.size() > 0 && $urandom_range(99) < vld_pct) begin
      vld_i = 1'b1; data_i = src_q[0];
    end else begin
      vld_i = 1'b0; data_i = DW'($urandom);
    end
    blk_rdy_i = ($urandom_range(99) < blk_rdy_pct);
    flush_i   = force_flush || ($urandom_range(999) < flush_pmil);
    drive_buf();
    #1;
    e_rdy  = !flush_i && buf_rdy_i[mwr];
    e_acc  = vld_i && e_rdy;
    e_push = 2'b00; e_bvo = 2'b00; e_brdy = 2'b00;
    if (e_acc) e_push[mwr] = 1'b1;
    if (e_acc && mcnt == ND) e_bvo[mwr] = 1'b1;
    e_brdy[mrd] = blk_rdy_i;
    e_bv = !flush_i && exp_q.size() > 0 && exp_q[0].rc <= cyc;
    chk("rdy_o",      128'(rdy_o),      128'(e_rdy));
    chk("buf_push_o", 128'(buf_push_o), 128'(e_push));
    chk("buf_vld_o",  128'(buf_vld_o),  128'(e_bvo));
    chk("buf_clr_o",  128'(buf_clr_o),  128'(flush_i));
    chk("buf_data_o", 128'(buf_data_o), 128'(data_i));
    chk("blk_rdy_o",  128'(blk_rdy_o),  128'(e_brdy));
    chk("blk_vld_o",  128'(blk_vld_o),  128'(e_bv));
    chk("idle_o",     128'(idle_o),     128'(mcnt == 0 && exp_q.size() == 0));
    if (e_bv) chk("blk_o", 128'(blk_o), 128'(exp_q[0].blk));
    if (vld_i && !rdy_o) bubble_cnt++;
    s_push = buf_push_o; s_bvld = buf_vld_o; s_brdy = blk_rdy_o; s_bvi = blk_vld_i;
    s_clr = buf_clr_o; s_data = buf_data_o; s_flush = flush_i; s_brin = blk_rdy_i;
    @(posedge clk_i);
    // Scoreboard update.
    if (s_flush) begin
      model_reset();
    end else begin
      if (e_acc) begin
        mw[mcnt] = data_i;
        void'(src_q.pop_front());
        if (mcnt == ND) begin
          e.blk = mk_blk(mw); e.rc = cyc + 2;
          exp_q.push_back(e);
          mcnt = 0; mwr ^= 1;
        end else begin
          mcnt++;
        end
      end
      if (e_bv && s_brin) begin
        $display("blk out #%0d base=%02h cyc=%0d", out_cnt, exp_q[0].blk.base, cyc);
        out_cnt++;
        void'(exp_q.pop_front());
        mrd ^= 1;
      end
    end
    // Buffer models react to what the DUT actually did.
    if (s_clr) begin
      bufs_reset();
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (s_brdy[b] && s_bvi[b]) begin
          if (b == 0) void'(bq0.pop_front()); else void'(bq1.pop_front());
        end
        if (s_push[b] && pcnt[b] <= ND) begin
          part[b][pcnt[b]] = s_data;
          pcnt[b]++;
        end
        if (s_bvld[b]) begin
          for (int i = 0; i <= ND; i++) tmp[i] = part[b][i];
          e.blk = mk_blk(tmp); e.rc = cyc + 2;
          if (b == 0) bq0.push_back(e); else bq1.push_back(e);
          pcnt[b] = 0;
        end
      end
    end
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until all words are sent and every block has left; bounded.
  task automatic drain(input string tag, input int max);
    int n = 0;
    while ((src_q.size() > 0 || mcnt != 0 || exp_q.size() > 0) && n < max) begin
      if (src_q.size() == 0 && mcnt != 0)
        for (int i = mcnt; i <= ND; i++) src_q.push_back(DW'($urandom));
      step();
      n++;
    end
    chk(tag, 128'(n < max), 128'(1));
  endtask

  initial begin
    int base_out;
    vld_i = 1'b0; data_i = '0; flush_i = 1'b0; blk_rdy_i = 1'b0;
    buf_rdy_i = 2'b01; blk_vld_i = 2'b00; blk_i = '0;
    cyc = 0;
    model_reset(); bufs_reset();

    // Reset state while rst_ni is held low.
    #7;
    chk("rst_idle",   128'(idle_o),     128'(1));
    chk("rst_push",   128'(buf_push_o), 128'(0));
    chk("rst_bvld",   128'(buf_vld_o),  128'(0));
    chk("rst_clr",    128'(buf_clr_o),  128'(0));
    chk("rst_blkvld", 128'(blk_vld_o),  128'(0));
    chk("rst_rdy0",   128'(rdy_o),      128'(1));
    buf_rdy_i = 2'b10; #1;
    chk("rst_rdy1",   128'(rdy_o),      128'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single block: base 0x80 then 0xFF planes, downstream always ready.
    base_out = out_cnt;
    push_block(8'h80, 8'hFF, 0);
    drain("single_done", 60);
    chk("single_count", 128'(out_cnt - base_out), 128'(1));

    // Four back-to-back blocks, no upstream bubbles expected.
    bubble_cnt = 0; base_out = out_cnt;
    for (int k = 1; k <= 4; k++) push_block(DW'(k), 8'hA5, 1);
    drain("b2b_done", 120);
    chk("b2b_bubbles", 128'(bubble_cnt), 128'(0));
    chk("b2b_count",   128'(out_cnt - base_out), 128'(4));

    // Downstream stalled while streaming six blocks.
    blk_rdy_pct = 0;
    for (int k = 1; k <= 6; k++) push_block(DW'(8'h10 + k), 8'h00, 1);
    run(80);
    chk("stall_rdy",  128'(rdy_o),  128'(0));
    chk("stall_idle", 128'(idle_o), 128'(0));
    blk_rdy_pct = 100;
    drain("stall_drain", 200);

    // Flush after 5 words of block 2 with block 1 pending.
    blk_rdy_pct = 0;
    push_block(8'h21, 8'h00, 1);
    for (int i = 0; i < 5; i++) src_q.push_back(DW'($urandom));
    run(20);
    force_flush = 1; step(); force_flush = 0;
    chk("flush_idle", 128'(idle_o), 128'(1));
    run(6);
    blk_rdy_pct = 100;
    push_block(8'h30, 8'h55, 0);
    drain("flush_restart", 60);

    // Last-word accept coinciding with a drain of the pending block.
    blk_rdy_pct = 0;
    push_block(8'h41, 8'h00, 1);
    push_block(8'h42, 8'h00, 1);
    for (int i = 0; i < 40 && src_q.size() > 1; i++) step();
    blk_rdy_pct = 100;
    step();
    push_block(8'h43, 8'h00, 1);
    drain("simul_drain", 80);

    // Randomised traffic with buffer stalls and occasional flushes.
    vld_pct = 70; blk_rdy_pct = 60; stall_pct = 15; flush_pmil = 8;
    for (int k = 0; k < 40; k++) push_block(DW'(k), 8'h00, 1);
    run(1500);
    vld_pct = 100; blk_rdy_pct = 100; stall_pct = 0; flush_pmil = 0;
    drain("rand_drain", 2000);

    // Asynchronous reset in the middle of a block.
    push_block(8'h60, 8'h00, 1);
    run(4);
    vld_i = 1'b0;
    #2 rst_ni = 1'b0;
    model_reset(); bufs_reset();
    blk_vld_i = 2'b00; buf_rdy_i = 2'b01;
    #1;
    chk("arst_idle",   128'(idle_o),     128'(1));
    chk("arst_push",   128'(buf_push_o), 128'(0));
    chk("arst_blkvld", 128'(blk_vld_o),  128'(0));
    chk("arst_rdy",    128'(rdy_o),      128'(1));
    @(negedge clk_i);
    rst_ni = 1'b1;
    src_q.delete();
    push_block(8'h70, 8'h3C, 0);
    drain("arst_restart", 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule
